// File: rtl/tone_pkg.sv
// Shared constants, state encoding and half-period helpers for the tone driver.
package tone_pkg;

  localparam int unsigned NOTE_REST_MIN = 12;
  localparam int unsigned N_NOTES       = 12;

  // Base-octave (C4..B4) note frequencies in centi-Hz.
  localparam int unsigned FREQ_CHZ [N_NOTES] = '{
    26163, 27718, 29366, 31113, 32963, 34923,
    36999, 39200, 41530, 44000, 46616, 49388
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_SWITCH = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Base-octave half-period in clock cycles; 64-bit so 100 MHz * 100 does not overflow.
  function automatic int unsigned half_tbl(input int unsigned clk_frq, input logic [3:0] n);
    longint unsigned num;
    longint unsigned den;
    num = 64'(clk_frq) * 64'd100;
    den = 64'd2 * 64'(FREQ_CHZ[n]);
    return 32'(num / den);
  endfunction

  // Octave shift of a base half-period, clamped so the counter always has two states.
  function automatic int unsigned half_period(input int unsigned base, input logic [2:0] oct);
    int unsigned v;
    v = base >> oct;
    return (v < 32'd2) ? 32'd2 : v;
  endfunction

endpackage

// File: rtl/tone_driver.sv
// Square-wave tone generator with glitch-free pitch switching and minimum note hold.
module tone_driver
  import tone_pkg::*;
#(
  parameter int unsigned C_CLK_FRQ  = 100_000_000,
  parameter int unsigned C_MIN_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       note_valid,
  output logic       note_ready,
  input  logic [3:0] note_code,
  input  logic [2:0] note_octave,
  input  logic       note_on,
  output logic       spk_out,
  output logic       busy
);

  localparam int unsigned HALF_TBL [N_NOTES] = '{
    half_tbl(C_CLK_FRQ, 4'd0),  half_tbl(C_CLK_FRQ, 4'd1),  half_tbl(C_CLK_FRQ, 4'd2),
    half_tbl(C_CLK_FRQ, 4'd3),  half_tbl(C_CLK_FRQ, 4'd4),  half_tbl(C_CLK_FRQ, 4'd5),
    half_tbl(C_CLK_FRQ, 4'd6),  half_tbl(C_CLK_FRQ, 4'd7),  half_tbl(C_CLK_FRQ, 4'd8),
    half_tbl(C_CLK_FRQ, 4'd9),  half_tbl(C_CLK_FRQ, 4'd10), half_tbl(C_CLK_FRQ, 4'd11)
  };
  // C4 is the longest half-period, so it sizes the period counter.
  localparam int unsigned HP_MAX   = half_tbl(C_CLK_FRQ, 4'd0);
  localparam int unsigned PW       = $clog2(HP_MAX + 1);
  localparam int unsigned HOLD_CYC = 32'(64'(C_MIN_HOLD) * 64'(C_CLK_FRQ) / 64'd1000);
  localparam int unsigned HW       = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC);

  state_t          r_state;
  logic [PW-1:0]   r_hp;
  logic [PW-1:0]   r_pend;
  logic [PW-1:0]   r_cnt;
  logic [HW-1:0]   r_hold;
  logic            r_spk;
  logic            r_busy;
  logic            r_ready;

  logic            w_playable;
  logic            w_accept;
  logic            w_boundary;
  logic [3:0]      w_idx;
  logic [PW-1:0]   w_hp_new;
  logic [HW-1:0]   w_hold_inc;

  // Command decode and half-period lookup for the presented note.
  assign w_playable = note_on && (note_code < 4'(NOTE_REST_MIN));
  assign w_idx      = w_playable ? note_code : 4'd0;
  assign w_hp_new   = PW'(half_period(HALF_TBL[w_idx], note_octave));
  assign w_accept   = note_valid && r_ready;
  assign w_boundary = (r_cnt == (r_hp - PW'(1)));
  assign w_hold_inc = (r_hold == HOLD_MAX) ? r_hold : (r_hold + HW'(1));

  assign note_ready = r_ready;
  assign spk_out    = r_spk;
  assign busy       = r_busy;

  // Note FSM, period/hold counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_hp    <= '0;
      r_pend  <= '0;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_spk   <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_spk   <= 1'b0;
          r_cnt   <= '0;
          r_hold  <= '0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          if (w_accept && w_playable) begin
            r_hp    <= w_hp_new;
            r_spk   <= 1'b1;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_state <= ST_PLAY;
          end
        end

        ST_PLAY: begin
          if (w_boundary) begin
            r_spk <= ~r_spk;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + PW'(1);
          end
          r_hold  <= w_hold_inc;
          r_ready <= (w_hold_inc == HOLD_MAX);
          // A toggle on the accept cycle still happens; the new note waits for the next boundary.
          if (w_accept) begin
            r_ready <= 1'b0;
            if (w_playable) begin
              r_pend  <= w_hp_new;
              r_state <= ST_SWITCH;
            end else begin
              r_state <= ST_STOP;
            end
          end
        end

        ST_SWITCH: begin
          r_ready <= 1'b0;
          if (w_boundary) begin
            r_spk   <= ~r_spk;
            r_cnt   <= '0;
            r_hp    <= r_pend;
            r_hold  <= '0;
            r_state <= ST_PLAY;
          end else begin
            r_cnt <= r_cnt + PW'(1);
          end
        end

        ST_STOP: begin
          r_ready <= 1'b0;
          if (!r_spk || w_boundary) begin
            r_spk   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + PW'(1);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
